point_decompress: RTL

- Decoder partner to the ECC point generator / ECDH key-exchange path.
- Peer public keys are sent compressed as (x, parity of y). This block recovers the full affine point (x, y) on y^2 = x^3 + b mod p, or flags the input as not on the curve.
- Accepts one request at a time over a valid/ready handshake. Results are presented over a second valid/ready handshake, ready for the secret-generation point_gen instance.

---
 rtl/ecc_pkg.sv | 17 +
 rtl/mod_mul.sv | 19 +
 rtl/point_decompress.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC definitions: default field width, element type and the
// decompressor's state encoding. Also used by the point_gen path.
package ecc_pkg;

  localparam int ECC_WIDTH = 5;

  typedef logic [ECC_WIDTH-1:0] felem_t;

  typedef enum logic [2:0] {
    IDLE,
    RHS1,
    RHS2,
    SEARCH,
    DONE
  } state_e;

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiplier: r = (a * b) mod p.
// The product is formed at full 2*WIDTH precision before reduction so no
// high bits are lost for any operand pair below 2^WIDTH.
module mod_mul
  import ecc_pkg::*;
#(
  parameter int WIDTH = ECC_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] r_o
);

  // Widen, multiply, reduce; the remainder is always < p so it fits WIDTH bits.
  assign r_o = WIDTH'(({{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i})
                      % {{WIDTH{1'b0}}, p_i});

endmodule

// File: rtl/point_decompress.sv
// Compressed-point decoder: given (x, parity of y) recovers y on
// y^2 = x^3 + b mod p by evaluating the right-hand side and then scanning
// candidate roots one per cycle. A single mod_mul is shared by x^2, x^3
// and y^2, its operands selected by the current state.
module point_decompress
  import ecc_pkg::*;
#(
  parameter int WIDTH = ECC_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic             in_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             out_err
);

  state_e           state_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] x_q;
  logic             par_q;
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] rhs_q;
  logic [WIDTH-1:0] y_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_x_q;
  logic [WIDTH-1:0] out_y_q;
  logic             out_err_q;

  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_r;
  logic [WIDTH:0]   rhs_sum;
  logic [WIDTH-1:0] rhs_d;
  logic [WIDTH-1:0] sel_y_d;
  logic             sel_err_d;

  mod_mul #(.WIDTH(WIDTH)) u_mod_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_i (p_q),
    .r_o (mul_r)
  );

  // Share the multiplier: x*x in RHS1, t*x in RHS2, y*y while searching.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mul_a = x_q;
    mul_b = x_q;
    case (state_q)
      RHS2:    mul_a = t_q;
      SEARCH: begin
        mul_a = y_q;
        mul_b = y_q;
      end
      default: ;
    endcase
  end

  // rhs = (x^3 mod p + b) mod p; both terms are < p, so one conditional subtract suffices.
  assign rhs_sum = {1'b0, mul_r} + {1'b0, b_q};
  assign rhs_d   = (rhs_sum >= {1'b0, p_q}) ? WIDTH'(rhs_sum - {1'b0, p_q})
                                            : rhs_sum[WIDTH-1:0];

  // Pick the root with the requested parity; a zero root has no odd partner.
  always_comb begin
    sel_y_d   = '0;
    sel_err_d = 1'b0;
    if (y_q == '0) begin
      sel_err_d = par_q;
    end else if (y_q[0] == par_q) begin
      sel_y_d = y_q;
    end else begin
      sel_y_d = p_q - y_q;
    end
  end

  // Control FSM and datapath registers, with registered handshake outputs.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state_q     <= IDLE;
      p_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      par_q       <= 1'b0;
      t_q         <= '0;
      rhs_q       <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            p_q        <= p;
            b_q        <= b;
            x_q        <= in_x;
            par_q      <= in_parity;
            in_ready_q <= 1'b0;
            if (in_x < p) begin
              state_q <= RHS1;
            end else begin
              // x outside the field: reject without touching the multiplier.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_x_q     <= in_x;
              out_y_q     <= '0;
              out_err_q   <= 1'b1;
            end
          end
        end
        RHS1: begin
          t_q     <= mul_r;
          state_q <= RHS2;
        end
        RHS2: begin
          rhs_q   <= rhs_d;
          y_q     <= '0;
          state_q <= SEARCH;
        end
        SEARCH: begin
          if (mul_r == rhs_q) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_x_q     <= x_q;
            out_y_q     <= sel_y_d;
            out_err_q   <= sel_err_d;
          end else if (y_q == p_q - WIDTH'(1)) begin
            // Every residue tried: rhs is a non-residue, x is not on the curve.
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_x_q     <= x_q;
            out_y_q     <= '0;
            out_err_q   <= 1'b1;
          end else begin
            y_q <= y_q + WIDTH'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_err   = out_err_q;

endmodule
